// File: rtl/neuron_pkg.sv
// neuron_pkg -- shared definitions for the neuron weight RAM.
//   state_e   : controller states (ST_CLEAR sweeps the array, ST_READY serves
//               reads and writes).
//   rd_sel_e  : source of the registered read result.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths.
package neuron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // RD_ZERO covers both the reset value and out-of-range reads.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_BYP  = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/neuron_ram_core.sv
// neuron_ram_core -- plain simple-dual-port synchronous array.
// Ports:
//   clk      : clock
//   we_i     : write enable; wdata_i is stored at waddr_i on the rising edge
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o loads mem[raddr_i] on the rising edge
//   raddr_i  : read address
//   rdata_o  : registered read data, holds while re_i is low
// A same-edge read and write to one address returns the old contents.
// Callers must keep addresses below DEPTH whenever the enables are high.
module neuron_ram_core
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_weight_ram.sv
// neuron_weight_ram -- weight store with a clear sweep controller.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   read_address   : read address;  oe  : read enable
//   read_data      : registered read result (1-cycle latency)
//   read_valid     : one-cycle pulse marking new read_data
//   write_address  : write address; write_data : data; wre : write enable
//   clear          : refill the whole array with INIT_VAL
//   busy           : high while a clear sweep runs (and during reset)
// Build option: define NEURON_RAM_BYPASS_EN for write-first behaviour on a
// same-edge read/write to one address; otherwise the read sees the old word.
module neuron_weight_ram
  import neuron_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              oe,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              wre,
  input  logic              clear,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  rd_sel_e           sel_q, sel_d;
  logic [DATA_W-1:0] byp_q, byp_d;
  logic              rv_q, rv_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic rd_ok, wr_ok, bypass_hit;

  assign rd_ok = {1'b0, read_address}  < DEPTH_V;
  assign wr_ok = {1'b0, write_address} < DEPTH_V;

`ifdef NEURON_RAM_BYPASS_EN
  assign bypass_hit = wre && wr_ok && (read_address == write_address);
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    byp_d     = byp_q;
    rv_d      = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = write_address;
    ram_wdata = write_data;
    case (state_q)
      ST_CLEAR: begin
        // Sweep owns the write port; all external requests are ignored.
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = INIT_VAL;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        ram_we = wre && wr_ok;
        if (oe) begin
          rv_d = 1'b1;
          if (!rd_ok) begin
            sel_d = RD_ZERO;
          end else if (bypass_hit) begin
            // Capture the incoming word; the array read is skipped so the
            // core output register keeps its old value untouched.
            sel_d = RD_BYP;
            byp_d = write_data;
          end else begin
            sel_d  = RD_RAM;
            ram_re = 1'b1;
          end
        end
        // Requests on this edge above still complete before the sweep.
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      sel_q   <= RD_ZERO;
      byp_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      byp_q   <= byp_d;
      rv_q    <= rv_d;
    end
  end

  neuron_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (read_address),
    .rdata_o (ram_rdata)
  );

  // The core register only loads on RD_RAM reads, so every source holds
  // its value while oe is low.
  always_comb begin
    case (sel_q)
      RD_RAM:  read_data = ram_rdata;
      RD_BYP:  read_data = byp_q;
      default: read_data = '0;
    endcase
  end

  assign read_valid = rv_q;
  assign busy       = (state_q == ST_CLEAR);

endmodule
